cpu_mem_sys: RTL

Synthesizable, parametrised instruction/data memory subsystem for `instruction_set_model`. It replaces the behavioural memory arrays and `$readmemb` preload with:
- two on-chip memories and a configurable read pipeline
- byte-enabled data writes
- a load port for program preload
- a run-cycle watchdog with halt control

It sits between the CPU's `MEM_*` / `INS_*` ports and the bench or SoC top.

---
 rtl/cpu_mem_sys.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cpu_mem_sys.sv
// cpu_mem_sys: instruction/data memory pair with preload port, byte-enabled
// CPU writes, configurable read pipeline and a RUN-cycle watchdog.
module cpu_mem_sys #(
  parameter int WIDTH      = 32,
  parameter int ADDRSIZE   = 12,
  parameter int DEPTH      = 4096,
  parameter int RD_LATENCY = 1,
  parameter int MAX_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRSIZE-1:0]   MEM_ADDR,
  input  logic [WIDTH-1:0]      MEM_OUT,
  input  logic                  MEM_CTRL,
  input  logic [WIDTH/8-1:0]    MEM_BE,
  output logic [WIDTH-1:0]      MEM_IN,
  input  logic [ADDRSIZE-1:0]   INS_ADDR,
  output logic [WIDTH-1:0]      INS_MEM,
  input  logic                  LD_VALID,
  input  logic                  LD_SEL,
  input  logic [ADDRSIZE-1:0]   LD_ADDR,
  input  logic [WIDTH-1:0]      LD_DATA,
  input  logic                  LD_DONE,
  output logic                  LD_READY,
  input  logic                  HALT_REQ,
  output logic                  HALTED,
  output logic [1:0]            HALT_CAUSE,
  output logic [31:0]           CYCLES,
  output logic                  ERR
);
  localparam int NBE = WIDTH / 8;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_e;

  state_e            state_q;
  logic              ld_ready_q, halted_q, err_q;
  logic [1:0]        cause_q;
  logic [31:0]       cycles_q;

  logic [WIDTH-1:0]  dmem [DEPTH];
  logic [WIDTH-1:0]  imem [DEPTH];

  logic [RD_LATENCY-1:0][WIDTH-1:0] dpipe_q, ipipe_q;

  // Range check widened to 32 bits so DEPTH == 2**ADDRSIZE compares cleanly.
  function automatic logic in_rng(input logic [ADDRSIZE-1:0] a);
    return {{(32-ADDRSIZE){1'b0}}, a} < DEPTH;
  endfunction

  logic d_ok, i_ok, ld_ok, cpu_wr, ld_wr, wd_hit;
  assign d_ok   = in_rng(MEM_ADDR);
  assign i_ok   = in_rng(INS_ADDR);
  assign ld_ok  = in_rng(LD_ADDR);
  assign cpu_wr = (state_q == S_RUN)  && MEM_CTRL;
  assign ld_wr  = (state_q == S_LOAD) && LD_VALID;
  assign wd_hit = (MAX_CYCLES != 0) && (cycles_q == 32'(MAX_CYCLES - 1));

  // Data-memory write port: CPU byte writes in RUN, full-word loads in LOAD.
  logic                  dwe;
  logic [ADDRSIZE-1:0]   dwa;
  logic [NBE-1:0]        dbe;
  logic [WIDTH-1:0]      dwdat, dmask;
  logic                  iwe;

  // Select the single data-memory writer for this cycle and drop out-of-range writes.
  always_comb begin
    dwe   = 1'b0;
    dwa   = MEM_ADDR;
    dbe   = '0;
    dwdat = MEM_OUT;
    if (cpu_wr && d_ok) begin
      dwe = 1'b1;
      dbe = MEM_BE;
    end else if (ld_wr && !LD_SEL && ld_ok) begin
      dwe   = 1'b1;
      dwa   = LD_ADDR;
      dbe   = '1;
      dwdat = LD_DATA;
    end
    for (int b = 0; b < NBE; b++) dmask[b*8 +: 8] = {8{dbe[b]}};
  end

  assign iwe = ld_wr && LD_SEL && ld_ok;

  // Write-first read data: a same-edge write to the read address is forwarded merged.
  logic [WIDTH-1:0] d_old, d_rd, i_rd;
  assign d_old = dmem[MEM_ADDR[AW-1:0]];
  assign d_rd  = !d_ok ? '0 :
                 (dwe && dwa == MEM_ADDR) ? ((d_old & ~dmask) | (dwdat & dmask)) : d_old;
  assign i_rd  = !i_ok ? '0 :
                 (iwe && LD_ADDR == INS_ADDR) ? LD_DATA : imem[INS_ADDR[AW-1:0]];

  // Memory arrays are not reset so contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (dwe)
      for (int b = 0; b < NBE; b++)
        if (dbe[b]) dmem[dwa[AW-1:0]][b*8 +: 8] <= dwdat[b*8 +: 8];
    if (iwe) imem[LD_ADDR[AW-1:0]] <= LD_DATA;
  end

  // Read pipeline: stage 0 captures the read, later stages only delay it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dpipe_q <= '0;
      ipipe_q <= '0;
    end else begin
      dpipe_q[0] <= d_rd;
      ipipe_q[0] <= i_rd;
      for (int s = 1; s < RD_LATENCY; s++) begin
        dpipe_q[s] <= dpipe_q[s-1];
        ipipe_q[s] <= ipipe_q[s-1];
      end
    end
  end

  // Control FSM: LOAD -> RUN -> HALT, with cycle counter, halt cause and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      ld_ready_q <= 1'b1;
      halted_q   <= 1'b0;
      cause_q    <= 2'b00;
      cycles_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      // Reads are active every cycle, so an out-of-range read address flags too.
      if (!d_ok || !i_ok || (ld_wr && !ld_ok)) err_q <= 1'b1;
      case (state_q)
        S_LOAD: if (LD_DONE) begin
          state_q    <= S_RUN;
          ld_ready_q <= 1'b0;
        end
        S_RUN: begin
          cycles_q <= cycles_q + 32'd1;
          if (HALT_REQ || wd_hit) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            cause_q  <= {wd_hit, HALT_REQ};
          end
        end
        default: ;
      endcase
    end
  end

  assign MEM_IN     = dpipe_q[RD_LATENCY-1];
  assign INS_MEM    = ipipe_q[RD_LATENCY-1];
  assign LD_READY   = ld_ready_q;
  assign HALTED     = halted_q;
  assign HALT_CAUSE = cause_q;
  assign CYCLES     = cycles_q;
  assign ERR        = err_q;
endmodule
